// File: rtl/dma_out_stream.sv
// dma_out_stream: memory-to-stream DMA reader; word reads are buffered in a
// credit-limited FIFO and replayed in order on t0 with t0_last on the final beat.
module dma_out_stream #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [31:0]       ctimer,
    input  logic              config_valid,
    output logic              config_ready,
    input  logic [31:0]       config_payload_startAddr,
    input  logic [31:0]       config_payload_length,
    input  logic [31:0]       config_payload_timerInit,
    input  logic              dmaReset,
    output logic              busy,
    output logic              strobe_complete,
    output logic              interrupt,
    input  logic              interrupt_clear,
    output logic [31:0]       o0_addr,
    output logic              o0_valid,
    input  logic              o0_ready,
    input  logic [DATA_W-1:0] o0_rdata,
    input  logic              o0_rvalid,
    output logic [DATA_W-1:0] t0_data,
    output logic              t0_valid,
    input  logic              t0_ready,
    output logic              t0_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, ABORT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d, len_q, len_d, req_q, req_d, beat_q, beat_d;
    logic [CW-1:0]     out_q, out_d, cnt_q, cnt_d;
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              strobe_q, strobe_d, irq_q, irq_d;
    logic              acc_cfg, zero, req, rsp, wr, pop, last, abort, done, set;

    assign acc_cfg = state_q == IDLE && config_valid &&
                     (ctimer == config_payload_timerInit || &config_payload_timerInit);
    assign zero    = config_payload_length == 32'd0;
    // Credits cover both buffered and in-flight words, so every response has a slot.
    assign o0_valid = state_q == READ &&
                      (CW+1)'(cnt_q) + (CW+1)'(out_q) < (CW+1)'(FIFO_DEPTH);
    assign req     = o0_valid && o0_ready;
    assign rsp     = o0_rvalid && out_q != '0;
    assign wr      = rsp && state_q != ABORT;
    assign t0_valid = cnt_q != '0 && state_q != ABORT;
    assign pop     = t0_valid && t0_ready;
    assign last    = beat_q == len_q - 32'd1;
    assign t0_last = t0_valid && last;
    assign t0_data = mem_q[rp_q];
    assign abort   = dmaReset && (state_q == READ || state_q == DRAIN);
    assign done    = pop && last && state_q == DRAIN && !dmaReset;
    assign set     = done || (acc_cfg && zero);

    assign config_ready    = acc_cfg;
    assign busy            = state_q != IDLE;
    assign strobe_complete = strobe_q;
    assign interrupt       = irq_q;
    assign o0_addr         = addr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = req ? addr_q + 32'd1 : addr_q;
        len_d    = len_q;
        req_d    = req ? req_q + 32'd1 : req_q;
        beat_d   = pop ? beat_q + 32'd1 : beat_q;
        out_d    = out_q + CW'(req) - CW'(rsp);
        cnt_d    = cnt_q + CW'(wr) - CW'(pop);
        wp_d     = wr ? wp_q + AW'(1) : wp_q;
        rp_d     = pop ? rp_q + AW'(1) : rp_q;
        mem_d    = mem_q;
        if (wr) mem_d[wp_q] = o0_rdata;
        strobe_d = set;
        irq_d    = set ? 1'b1 : (interrupt_clear ? 1'b0 : irq_q);
        if (acc_cfg) begin
            addr_d  = config_payload_startAddr;
            len_d   = config_payload_length;
            req_d   = '0;
            beat_d  = '0;
            state_d = zero ? IDLE : READ;
        end else if (abort) begin
            state_d = ABORT;
        end else if (state_q == READ && req && req_q == len_q - 32'd1) begin
            state_d = DRAIN;
        end else if (done || (state_q == ABORT && out_q == '0)) begin
            state_d = IDLE;
        end
        if (state_q == ABORT) begin
            cnt_d = '0;
            wp_d  = '0;
            rp_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            req_q    <= '0;
            beat_q   <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            strobe_q <= 1'b0;
            irq_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            req_q    <= req_d;
            beat_q   <= beat_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            strobe_q <= strobe_d;
            irq_q    <= irq_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_dma_out_stream.sv
// tb_dma_out_stream: directed checks of dma_out_stream against a 2-cycle-latency
// memory whose read data is the bitwise inverse of the address.
module tb_dma_out_stream;
    logic        clk, srst;
    logic [31:0] ctimer;
    logic        config_valid, config_ready;
    logic [31:0] cfg_addr, cfg_len, cfg_tinit;
    logic        dmaReset, busy, strobe_complete, interrupt, interrupt_clear;
    logic [31:0] o0_addr, o0_rdata, t0_data;
    logic        o0_valid, o0_ready, o0_rvalid, t0_valid, t0_ready, t0_last;

    int checks = 0;
    int errors = 0;
    logic [31:0] reqs[$];
    logic [31:0] beats[$];
    bit          lasts[$];
    int          strobes;

    dma_out_stream #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .srst(srst), .ctimer(ctimer),
        .config_valid(config_valid), .config_ready(config_ready),
        .config_payload_startAddr(cfg_addr), .config_payload_length(cfg_len),
        .config_payload_timerInit(cfg_tinit),
        .dmaReset(dmaReset), .busy(busy), .strobe_complete(strobe_complete),
        .interrupt(interrupt), .interrupt_clear(interrupt_clear),
        .o0_addr(o0_addr), .o0_valid(o0_valid), .o0_ready(o0_ready),
        .o0_rdata(o0_rdata), .o0_rvalid(o0_rvalid),
        .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready), .t0_last(t0_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        ctimer = 0;
        forever begin
            @(posedge clk);
            #1 ctimer = ctimer + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    // Memory model and stream/strobe monitor, all sampled on the falling edge.
    initial begin
        logic        p0v, p1v;
        logic [31:0] p0a, p1a;
        p0v = 0; p1v = 0; p0a = 0; p1a = 0;
        o0_rvalid = 0; o0_rdata = 0; strobes = 0;
        forever begin
            @(negedge clk);
            o0_rvalid = p1v;
            o0_rdata  = ~p1a;
            p1v = p0v; p1a = p0a;
            p0v = o0_valid && o0_ready;
            p0a = o0_addr;
            if (!srst) begin
                if (o0_valid && o0_ready) reqs.push_back(o0_addr);
                if (t0_valid && t0_ready) begin
                    beats.push_back(t0_data);
                    lasts.push_back(t0_last);
                end
                if (strobe_complete) strobes++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        @(posedge clk); #1;
        reqs.delete(); beats.delete(); lasts.delete(); strobes = 0;
    endtask

    task automatic cfg(input logic [31:0] a, input logic [31:0] l, input logic [31:0] t);
        @(posedge clk); #1;
        config_valid = 1; cfg_addr = a; cfg_len = l; cfg_tinit = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (config_ready) break;
        end
        chk("cfg_ready", 32'(config_ready), 1);
        @(posedge clk); #1;
        config_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_run(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_nreq"}, 32'(reqs.size()), 32'(n));
        chk({tag, "_nbeat"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < reqs.size(); i++)
            chk({tag, "_addr"}, reqs[i], base + 32'(i));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk({tag, "_data"}, beats[i], ~(base + 32'(i)));
            chk({tag, "_last"}, 32'(lasts[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        int pulses, at_t, n;
        logic busy_at, busy_nxt, prev;
        srst = 1; config_valid = 0; cfg_addr = 0; cfg_len = 0; cfg_tinit = 0;
        dmaReset = 0; interrupt_clear = 0; o0_ready = 1; t0_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_o0v", 32'(o0_valid), 0);
        chk("rst_t0v", 32'(t0_valid), 0);
        chk("rst_last", 32'(t0_last), 0);
        chk("rst_strobe", 32'(strobe_complete), 0);
        chk("rst_irq", 32'(interrupt), 0);
        chk("rst_cfgrdy", 32'(config_ready), 0);
        chk("rst_addr", o0_addr, 0);
        chk("rst_data", t0_data, 0);
        @(posedge clk); #1 srst = 0;

        // Timed start: config held from ctimer=40, accepted only at 50.
        clr();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ctimer == 39) break;
        end
        @(posedge clk); #1;
        config_valid = 1; cfg_addr = 32'h600; cfg_len = 2; cfg_tinit = 50;
        pulses = 0; at_t = 0; busy_at = 1; busy_nxt = 0; prev = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prev) busy_nxt = busy;
            prev = 0;
            if (config_ready) begin
                pulses++; at_t = int'(ctimer); busy_at = busy; prev = 1;
            end
        end
        @(posedge clk); #1 config_valid = 0;
        chk("t2_pulses", 32'(pulses), 1);
        chk("t2_time", 32'(at_t), 50);
        chk("t2_busy_at", 32'(busy_at), 0);
        chk("t2_busy_nxt", 32'(busy_nxt), 1);
        wait_idle("t2");
        chk_run("t2", 32'h600, 2);

        // Basic 4-word transfer.
        clr();
        cfg(32'h100, 4, 32'hFFFFFFFF);
        wait_idle("t1");
        chk_run("t1", 32'h100, 4);
        if (beats.size() == 4) chk("t1_beat3", beats[3], 32'hFFFFFEFC);
        chk("t1_strobes", 32'(strobes), 1);
        chk("t1_irq", 32'(interrupt), 1);

        // Backpressure: credits stop reads at FIFO_DEPTH.
        clr();
        t0_ready = 0;
        cfg(32'h200, 8, 32'hFFFFFFFF);
        repeat (20) @(negedge clk);
        chk("t3_nreq_stall", 32'(reqs.size()), 4);
        chk("t3_o0v_stall", 32'(o0_valid), 0);
        chk("t3_t0v_stall", 32'(t0_valid), 1);
        chk("t3_nbeat_stall", 32'(beats.size()), 0);
        @(posedge clk); #1 t0_ready = 1;
        wait_idle("t3");
        chk_run("t3", 32'h200, 8);
        chk("t3_strobes", 32'(strobes), 1);

        // Abort with two reads outstanding.
        @(posedge clk); #1 interrupt_clear = 1;
        @(posedge clk); #1 interrupt_clear = 0;
        @(negedge clk);
        chk("t4_irq_clr", 32'(interrupt), 0);
        clr();
        t0_ready = 0;
        cfg(32'h300, 6, 32'hFFFFFFFF);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o0_valid && o0_ready) n++;
            if (n == 3) break;
        end
        chk("t4_nacc", 32'(n), 3);
        @(posedge clk); #1 dmaReset = 1; o0_ready = 0;
        @(posedge clk); #1 dmaReset = 0;
        @(negedge clk);
        chk("t4_t0v", 32'(t0_valid), 0);
        chk("t4_busy", 32'(busy), 1);
        wait_idle("t4");
        chk("t4_strobes", 32'(strobes), 0);
        chk("t4_irq", 32'(interrupt), 0);
        chk("t4_nreq", 32'(reqs.size()), 3);
        chk("t4_nbeat", 32'(beats.size()), 0);
        @(posedge clk); #1 t0_ready = 1; o0_ready = 1;
        clr();
        cfg(32'h380, 2, 32'hFFFFFFFF);
        wait_idle("t4b");
        chk_run("t4b", 32'h380, 2);
        chk("t4b_strobes", 32'(strobes), 1);

        // Single beat, zero length, address wrap.
        clr();
        cfg(32'h400, 1, 32'hFFFFFFFF);
        wait_idle("t5a");
        chk_run("t5a", 32'h400, 1);
        clr();
        cfg(32'h500, 0, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t5b_strobe", 32'(strobe_complete), 1);
        chk("t5b_busy", 32'(busy), 0);
        chk("t5b_irq", 32'(interrupt), 1);
        repeat (3) @(negedge clk);
        chk("t5b_nreq", 32'(reqs.size()), 0);
        chk("t5b_strobes", 32'(strobes), 1);
        clr();
        cfg(32'hFFFFFFFF, 2, 32'hFFFFFFFF);
        wait_idle("t5c");
        chk_run("t5c", 32'hFFFFFFFF, 2);
        if (reqs.size() == 2) chk("t5c_wrap", reqs[1], 32'h0);

        // Set beats a same-cycle clear.
        @(posedge clk); #1 interrupt_clear = 1;
        @(posedge clk); #1 interrupt_clear = 0;
        @(negedge clk);
        chk("t6_pre", 32'(interrupt), 0);
        @(posedge clk); #1;
        config_valid = 1; cfg_addr = 32'h700; cfg_len = 0; cfg_tinit = 32'hFFFFFFFF;
        interrupt_clear = 1;
        @(negedge clk);
        chk("t6_rdy", 32'(config_ready), 1);
        @(posedge clk); #1 config_valid = 0; interrupt_clear = 0;
        @(negedge clk);
        chk("t6_set_wins", 32'(interrupt), 1);
        @(posedge clk); #1 interrupt_clear = 1;
        @(posedge clk); #1 interrupt_clear = 0;
        @(negedge clk);
        chk("t6_cleared", 32'(interrupt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
